// File: rtl/counter_mod_n.sv
// Modulo-N up/down counter with load, free-run/one-shot modes and a terminal-count pulse.
// Latency: o_cnt/o_tc update one cycle after the controlling inputs; o_busy/o_done follow state.
// Backpressure: none; i_en gates stepping, and the counter holds while it is low.
module counter_mod_n #(
    parameter int MOD_N = 100,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_up,
    input  logic             i_start,
    input  logic             i_one_shot,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_tc,
    output logic             o_busy,
    output logic             o_done
);

    if (MOD_N < 2) begin : g_bad_mod
        $error("counter_mod_n: MOD_N must be at least 2");
    end
    if ((2 ** CNT_W) < MOD_N) begin : g_bad_width
        $error("counter_mod_n: CNT_W too narrow for MOD_N");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MOD_N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t state;
    logic   one_shot_q;
    logic   at_term;

    // Terminal value follows the direction requested this cycle.
    assign at_term = i_up ? (o_cnt == CNT_MAX) : (o_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            one_shot_q <= 1'b0;
            o_cnt      <= '0;
            o_tc       <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_tc <= 1'b0;
            if (i_load) begin
                o_cnt <= (i_load_val > CNT_MAX) ? CNT_MAX : i_load_val;
            end else if (i_start && (state != RUN)) begin
                state      <= RUN;
                o_busy     <= 1'b1;
                o_done     <= 1'b0;
                one_shot_q <= i_one_shot;
                o_cnt      <= i_up ? '0 : CNT_MAX;
            end else if ((state == RUN) && i_en) begin
                if (at_term) begin
                    o_tc <= 1'b1;
                    if (one_shot_q) begin
                        state  <= DONE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end else begin
                        o_cnt <= i_up ? '0 : CNT_MAX;
                    end
                end else begin
                    o_cnt <= i_up ? (o_cnt + CNT_ONE) : (o_cnt - CNT_ONE);
                end
            end
        end
    end

endmodule

// File: tb/tb_counter_mod_n.sv
// Directed bench for counter_mod_n at MOD_N=100, CNT_W=7.
module tb_counter_mod_n;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_en;
    logic       i_up;
    logic       i_start;
    logic       i_one_shot;
    logic       i_load;
    logic [6:0] i_load_val;
    logic [6:0] o_cnt;
    logic       o_tc;
    logic       o_busy;
    logic       o_done;

    int n_chk = 0;
    int n_bad = 0;

    counter_mod_n #(.MOD_N(100), .CNT_W(7)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_en       (i_en),
        .i_up       (i_up),
        .i_start    (i_start),
        .i_one_shot (i_one_shot),
        .i_load     (i_load),
        .i_load_val (i_load_val),
        .o_cnt      (o_cnt),
        .o_tc       (o_tc),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic start(input logic up, input logic one_shot);
        i_up       = up;
        i_one_shot = one_shot;
        i_start    = 1'b1;
        tick();
        i_start    = 1'b0;
    endtask

    initial begin
        reset = 1'b1; i_en = 1'b0; i_up = 1'b1; i_start = 1'b0;
        i_one_shot = 1'b0; i_load = 1'b0; i_load_val = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_cnt", o_cnt, 0);
        chk("rst_tc", o_tc, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);

        // 1: free-run up, two wraps 100 cycles apart
        i_en = 1'b1;
        start(1'b1, 1'b0);
        chk("up_start_cnt", o_cnt, 0);
        chk("up_start_busy", o_busy, 1);
        for (int k = 1; k <= 99; k++) begin
            tick();
            chk("up_cnt", o_cnt, k);
            chk("up_tc_quiet", o_tc, 0);
        end
        tick();
        chk("up_wrap_cnt", o_cnt, 0);
        chk("up_wrap_tc", o_tc, 1);
        chk("up_wrap_busy", o_busy, 1);
        tick();
        chk("up_after_wrap_cnt", o_cnt, 1);
        chk("up_after_wrap_tc", o_tc, 0);
        for (int k = 2; k <= 99; k++) begin
            tick();
            chk("up_tc_quiet2", o_tc, 0);
        end
        tick();
        chk("up_wrap2_cnt", o_cnt, 0);
        chk("up_wrap2_tc", o_tc, 1);

        // 2: free-run down, wrap 0->99, then reverse at 50
        do_reset();
        start(1'b0, 1'b0);
        chk("dn_start_cnt", o_cnt, 99);
        for (int k = 98; k >= 0; k--) begin
            tick();
            chk("dn_cnt", o_cnt, k);
            chk("dn_tc_quiet", o_tc, 0);
        end
        tick();
        chk("dn_wrap_cnt", o_cnt, 99);
        chk("dn_wrap_tc", o_tc, 1);
        for (int k = 0; k < 49; k++) tick();
        chk("dn_at50", o_cnt, 50);
        i_up = 1'b1;
        tick();
        chk("rev_51", o_cnt, 51);
        tick();
        chk("rev_52", o_cnt, 52);

        // 3: one-shot up, finish at 99, restart
        do_reset();
        start(1'b1, 1'b1);
        for (int k = 0; k < 99; k++) tick();
        chk("os_cnt99", o_cnt, 99);
        chk("os_pre_done", o_done, 0);
        chk("os_pre_tc", o_tc, 0);
        tick();
        chk("os_done", o_done, 1);
        chk("os_busy", o_busy, 0);
        chk("os_tc", o_tc, 1);
        chk("os_hold", o_cnt, 99);
        tick();
        chk("os_tc_single", o_tc, 0);
        chk("os_hold2", o_cnt, 99);
        chk("os_done2", o_done, 1);
        start(1'b1, 1'b1);
        chk("os_restart_cnt", o_cnt, 0);
        chk("os_restart_busy", o_busy, 1);
        chk("os_restart_done", o_done, 0);

        // 4: loads, clamping, load beats start in IDLE
        tick();
        chk("ld_pre", o_cnt, 1);
        i_load = 1'b1; i_load_val = 7'd42;
        tick();
        chk("ld_42", o_cnt, 42);
        i_load = 1'b0;
        tick();
        chk("ld_step43", o_cnt, 43);
        i_load = 1'b1; i_load_val = 7'd120;
        tick();
        chk("ld_clamp120", o_cnt, 99);
        i_load_val = 7'd100;
        tick();
        chk("ld_clamp100", o_cnt, 99);
        i_load_val = 7'd99;
        tick();
        chk("ld_99", o_cnt, 99);
        chk("ld_no_tc", o_tc, 0);
        chk("ld_busy", o_busy, 1);
        i_load = 1'b0;
        do_reset();
        i_load = 1'b1; i_load_val = 7'd17; i_start = 1'b1;
        tick();
        i_load = 1'b0; i_start = 1'b0;
        chk("ld_idle_cnt", o_cnt, 17);
        chk("ld_idle_busy", o_busy, 0);
        tick();
        chk("ld_idle_hold", o_cnt, 17);

        // 5: enable gating and ignored start while running
        do_reset();
        start(1'b1, 1'b0);
        for (int k = 0; k < 30; k++) tick();
        chk("en_at30", o_cnt, 30);
        i_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("en_hold", o_cnt, 30);
            chk("en_tc", o_tc, 0);
        end
        i_en = 1'b1;
        tick();
        chk("en_resume", o_cnt, 31);
        i_up = 1'b1; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("run_start_ignored", o_cnt, 32);

        // 6: reset mid-count
        for (int k = 0; k < 25; k++) tick();
        chk("rst_mid_pre", o_cnt, 57);
        do_reset();
        chk("rst_mid_cnt", o_cnt, 0);
        chk("rst_mid_busy", o_busy, 0);
        chk("rst_mid_done", o_done, 0);
        chk("rst_mid_tc", o_tc, 0);
        for (int k = 0; k < 3; k++) tick();
        chk("rst_idle_hold", o_cnt, 0);
        chk("rst_idle_busy", o_busy, 0);
        start(1'b1, 1'b0);
        chk("rst_restart_busy", o_busy, 1);
        tick();
        chk("rst_restart_step", o_cnt, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
